// File: rtl/niosdramproc_hcsr04_ctrl.sv
// HC-SR04 ranger controller: Avalon-MM register slave that sequences the trigger pulse,
// times the echo pulse in clk cycles and enforces the re-trigger holdoff.
module niosdramproc_hcsr04_ctrl #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1900000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        echo_in,
    output logic        trig_out,
    output logic        irq
);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   echo_q, echo_d;
    logic               cont_q, cont_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               trig_q, trig_d;
    logic               irq_q, irq_d;
    logic               echo_meta_q, echo_s_q;
    logic               wr_ctrl_c, wr_stat_c;
    logic               unused_wdata;

    assign wr_ctrl_c    = chipselect & ~write_n & (address == 2'd0);
    assign wr_stat_c    = chipselect & ~write_n & (address == 2'd1);
    assign unused_wdata = ^writedata[31:3];
    assign trig_out     = trig_q;
    assign irq          = irq_q;

    // Register file updates and measurement sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        echo_d    = echo_q;
        cont_d    = cont_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        if (wr_ctrl_c) begin
            cont_d   = writedata[1];
            irq_en_d = writedata[2];
        end
        if (wr_stat_c) begin
            if (writedata[1]) done_d    = 1'b0;
            if (writedata[2]) timeout_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_ctrl_c && writedata[0]) state_d = TRIG;
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end
            end
            WAIT_RISE: begin
                // The detection cycle already saw echo_s high, so it is the first echo cycle.
                if (echo_s_q) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == RISE_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                end
            end
            MEASURE: begin
                if (!echo_s_q) begin
                    echo_d  = cnt_q;
                    done_d  = 1'b1;
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else if (cnt_q == ECHO_MAX) begin
                    echo_d    = ECHO_MAX;
                    timeout_d = 1'b1;
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLDOFF_LAST) begin
                    state_d = cont_q ? TRIG : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        trig_d = (state_d == TRIG);
        irq_d  = (done_q | timeout_q) & irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            echo_q      <= '0;
            cont_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            trig_q      <= 1'b0;
            irq_q       <= 1'b0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            echo_q      <= echo_d;
            cont_q      <= cont_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            trig_q      <= trig_d;
            irq_q       <= irq_d;
            echo_meta_q <= echo_in;
            echo_s_q    <= echo_meta_q;
        end
    end

    // Read mux; combinational from address as the bus expects zero wait states.
    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata = {29'd0, irq_en_q, cont_q, 1'b0};
            2'd1:    readdata = {29'd0, timeout_q, done_q, (state_q != IDLE)};
            2'd2:    readdata = 32'(echo_q);
            default: readdata = '0;
        endcase
    end

endmodule
